// File: rtl/conv_feeder.sv
// Streams a latched 3x3 binary kernel and then one feature map, bit-serially,
// into a convolution engine, fetching feature bytes through a one-deep prefetch.
module conv_feeder #(
  parameter int IMG0 = 784,
  parameter int IMG1 = 144
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_start,
  input  logic       cfg_mode,
  input  logic [8:0] cfg_weight,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       conv_done,
  output logic       start,
  output logic       din,
  output logic       state,
  output logic       weight_en,
  output logic       weight,
  output logic       busy,
  output logic       feed_done,
  output logic       err_underrun
);

  localparam int NMAX = (IMG0 > IMG1) ? IMG0 : IMG1;
  localparam int CW   = $clog2(NMAX) + 1;
  localparam int SW   = $clog2(NMAX / 8 + 1);

  localparam logic [CW-1:0] LAST0 = CW'(IMG0 - 1);
  localparam logic [CW-1:0] LAST1 = CW'(IMG1 - 1);
  localparam logic [CW-1:0] WLAST = CW'(8);
  localparam logic [SW-1:0] NB0   = SW'(IMG0 / 8);
  localparam logic [SW-1:0] NB1   = SW'(IMG1 / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_GAP, S_STREAM, S_WAIT_DONE, S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_q, mode_d;
  logic [8:0]      wgt_q, wgt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      pf_q, pf_d;
  logic            pf_full_q, pf_full_d;
  logic [SW-1:0]   slots_q, slots_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic            din_q, din_d;
  logic            mode_out_q, mode_out_d;
  logic            weight_en_q, weight_en_d;
  logic            weight_q, weight_d;
  logic            busy_q, busy_d;
  logic            feed_done_q, feed_done_d;
  logic            s_ready_q, s_ready_d;

  logic            hs;
  logic [CW-1:0]   last_cnt;
  logic [SW-1:0]   nbytes;
  logic            fetch_state;

  // Reset must block a held s_valid in the very cycle it is asserted.
  assign s_ready = s_ready_q & ~rst;
  assign hs      = s_valid & s_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    wgt_d     = wgt_q;
    shift_d   = shift_q;
    pf_d      = pf_q;
    pf_full_d = pf_full_q;
    slots_d   = slots_q;
    err_d     = err_q;
    din_d     = 1'b0;
    last_cnt  = mode_q ? LAST1 : LAST0;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d   = S_LOAD_W;
          cnt_d     = '0;
          mode_d    = cfg_mode;
          wgt_d     = cfg_weight;
          err_d     = 1'b0;
          shift_d   = '0;
          pf_full_d = 1'b0;
          slots_d   = '0;
        end
      end
      S_LOAD_W: begin
        if (cnt_q == WLAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      S_STREAM: begin
        if (cnt_q == last_cnt) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (conv_done) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // hs only happens with the prefetch empty, so it never collides with a reload.
    if (hs) begin
      pf_d      = s_data;
      pf_full_d = 1'b1;
      slots_d   = slots_q + SW'(1);
    end

    // Bits are produced against the cycle about to be entered so din stays registered.
    if (state_d == S_STREAM) begin
      if (cnt_d[2:0] == 3'd0) begin
        if (pf_full_q) begin
          shift_d   = {1'b0, pf_q[7:1]};
          din_d     = pf_q[0];
          pf_full_d = 1'b0;
        end else begin
          shift_d = '0;
          din_d   = 1'b0;
          err_d   = 1'b1;
          slots_d = slots_d + SW'(1);
        end
      end else begin
        din_d   = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
      end
    end

    nbytes      = mode_d ? NB1 : NB0;
    fetch_state = (state_d == S_LOAD_W) || (state_d == S_GAP) || (state_d == S_STREAM);
    start_d     = (state_d == S_STREAM);
    weight_en_d = (state_d == S_LOAD_W);
    weight_d    = (state_d == S_LOAD_W) ? wgt_d[cnt_d[3:0]] : 1'b0;
    busy_d      = (state_d != S_IDLE);
    feed_done_d = (state_d == S_FINISH);
    mode_out_d  = (state_d != S_IDLE) & mode_d;
    s_ready_d   = fetch_state && !pf_full_d && (slots_d < nbytes);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      wgt_q       <= '0;
      shift_q     <= '0;
      pf_q        <= '0;
      pf_full_q   <= 1'b0;
      slots_q     <= '0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      din_q       <= 1'b0;
      mode_out_q  <= 1'b0;
      weight_en_q <= 1'b0;
      weight_q    <= 1'b0;
      busy_q      <= 1'b0;
      feed_done_q <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      wgt_q       <= wgt_d;
      shift_q     <= shift_d;
      pf_q        <= pf_d;
      pf_full_q   <= pf_full_d;
      slots_q     <= slots_d;
      err_q       <= err_d;
      start_q     <= start_d;
      din_q       <= din_d;
      mode_out_q  <= mode_out_d;
      weight_en_q <= weight_en_d;
      weight_q    <= weight_d;
      busy_q      <= busy_d;
      feed_done_q <= feed_done_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign start        = start_q;
  assign din          = din_q;
  assign state        = mode_out_q;
  assign weight_en    = weight_en_q;
  assign weight       = weight_q;
  assign busy         = busy_q;
  assign feed_done    = feed_done_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_conv_feeder.sv
// Directed job sequence with random kernels/bytes for conv_feeder; each job's
// observed trace is compared against the expected bit stream built from the bytes.
module tb_conv_feeder;

  localparam int IMG0   = 784;
  localparam int IMG1   = 144;
  localparam int NBITS  = (IMG0 > IMG1) ? IMG0 : IMG1;
  localparam int BUDGET = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start, cfg_mode;
  logic [8:0] cfg_weight;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       conv_done;
  logic       start, din, state, weight_en, weight, busy, feed_done, err_underrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] byte_tab[0:NBITS/8-1];
  logic       din_rec[0:NBITS-1];

  conv_feeder #(.IMG0(IMG0), .IMG1(IMG1)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_weight(cfg_weight),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .conv_done(conv_done),
    .start(start), .din(din), .state(state), .weight_en(weight_en), .weight(weight),
    .busy(busy), .feed_done(feed_done), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {23'd0, start, din, state, weight_en, weight, s_ready, busy, feed_done, err_underrun};
  endfunction

  // skip_lo..skip_hi: byte slots the source withholds (-1 = none); abort_at: stream
  // cycle at which reset is forced (-1 = none); poke: spurious cfg_start/conv_done.
  task automatic run_job(input logic mode, input logic [8:0] w, input int skip_lo,
                         input int skip_hi, input int done_delay, input bit poke,
                         input int abort_at, input bit seq_data, input string name);
    int n, nslots, nskip, src, scnt, hs_cnt, wn, bad_state, fd_cnt, fd_cyc, cd_cyc;
    int first_st, last_st, last_we, wait_cnt, mism, cyc;
    bit done_sent, finished, withheld;
    logic [8:0] wgot;
    logic [7:0] b;
    n = mode ? IMG1 : IMG0;
    nslots = n / 8;
    nskip = (skip_lo >= 0) ? (skip_hi - skip_lo + 1) : 0;
    src = 0; scnt = 0; hs_cnt = 0; wn = 0; bad_state = 0; fd_cnt = 0;
    fd_cyc = -1; cd_cyc = -1; first_st = -1; last_st = -1; last_we = -1;
    wait_cnt = 0; done_sent = 0; finished = 0; wgot = '0;
    exp_q.delete();
    for (int s = 0; s < nslots; s++) begin
      byte_tab[s] = seq_data ? 8'(s + 1) : 8'($urandom_range(0, 255));
      exp_q.push_back((s >= skip_lo && s <= skip_hi) ? 8'h00 : byte_tab[s]);
    end
    for (int i = 0; i < NBITS; i++) din_rec[i] = 1'bx;

    cfg_start = 1'b1; cfg_mode = mode; cfg_weight = w; s_valid = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    for (cyc = 0; cyc < BUDGET && !finished; cyc++) begin
      if (cyc == 0) begin
        chk({name, "_err_clear"}, 32'(err_underrun), 32'd0);
        chk({name, "_we_first"}, 32'(weight_en), 32'd1);
      end
      if (fd_cyc >= 0 && cyc == fd_cyc + 1) begin
        chk({name, "_busy_after"}, 32'(busy), 32'd0);
        chk({name, "_err_held"}, 32'(err_underrun), 32'(nskip > 0));
        finished = 1;
        break;
      end
      if (weight_en) begin
        if (wn < 9) wgot[wn] = weight;
        wn++;
        last_we = cyc;
      end
      if (start) begin
        if (scnt < NBITS) din_rec[scnt] = din;
        scnt++;
        if (first_st < 0) first_st = cyc;
        last_st = cyc;
      end
      if (busy && !feed_done && state !== mode) bad_state++;
      if (weight_en && start) bad_state++;
      if (feed_done) begin
        fd_cnt++;
        if (fd_cyc < 0) fd_cyc = cyc;
      end

      cfg_start = 1'b0;
      conv_done = 1'b0;
      if (poke && (cyc == 3 || (start && scnt == 50))) begin
        cfg_start = 1'b1; cfg_mode = ~mode; cfg_weight = ~w;
        if (start) conv_done = 1'b1;
      end
      if (scnt >= n && !start && !done_sent) begin
        wait_cnt++;
        if (wait_cnt == done_delay) begin
          conv_done = 1'b1; cd_cyc = cyc; done_sent = 1;
        end
      end

      if (abort_at >= 0 && start && scnt == abort_at) begin
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hAA; cfg_start = 1'b0; conv_done = 1'b0;
        #1;
        chk({name, "_rst_ready"}, 32'(s_ready), 32'd0);
        @(negedge clk);
        chk({name, "_rst_outs"}, outs_vec(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk({name, "_post_rst_outs"}, outs_vec(), 32'd0);
        s_valid = 1'b0;
        return;
      end

      if (skip_lo >= 0 && src >= skip_lo && src <= skip_hi && scnt >= skip_hi * 8 + 1)
        src = skip_hi + 1;
      withheld = (skip_lo >= 0) && (src >= skip_lo) && (src <= skip_hi);
      s_valid = (src < nslots) && !withheld;
      s_data  = s_valid ? byte_tab[src] : 8'($urandom_range(0, 255));
      #1;
      if (s_valid && s_ready) begin
        hs_cnt++;
        src++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    conv_done = 1'b0;
    chk({name, "_finished"}, 32'(finished), 32'd1);

    mism = 0;
    for (int s = 0; s < nslots; s++) begin
      b = exp_q.pop_front();
      for (int k = 0; k < 8; k++)
        if (din_rec[s * 8 + k] !== b[k]) mism++;
    end
    chk({name, "_w_count"}, 32'(wn), 32'd9);
    chk({name, "_w_seq"}, 32'(wgot), 32'(w));
    chk({name, "_gap"}, 32'(first_st - last_we), 32'd2);
    chk({name, "_start_cnt"}, 32'(scnt), 32'(n));
    chk({name, "_start_contig"}, 32'(last_st - first_st + 1), 32'(n));
    chk({name, "_din_mism"}, 32'(mism), 32'd0);
    chk({name, "_handshakes"}, 32'(hs_cnt), 32'(nslots - nskip));
    chk({name, "_state_out"}, 32'(bad_state), 32'd0);
    chk({name, "_fd_once"}, 32'(fd_cnt), 32'd1);
    chk({name, "_fd_lat"}, 32'(fd_cyc), 32'(cd_cyc + 1));
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_weight = '0;
    s_valid = 1'b1; s_data = 8'h5A; conv_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs_vec(), 32'd0);
    rst = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs_vec(), 32'd0);

    run_job(1'b0, 9'h1A5, -1, -1, $urandom_range(1, 10), 1'b0, -1, 1'b1, "m0_seq");
    run_job(1'b1, 9'($urandom), -1, -1, 20, 1'b0, -1, 1'b0, "m1_d20");
    run_job(1'b1, 9'($urandom), 4, 5, $urandom_range(1, 8), 1'b0, -1, 1'b0, "m1_starve");
    run_job(1'b1, 9'($urandom), -1, -1, $urandom_range(1, 8), 1'b1, -1, 1'b0, "b2b_poke");
    run_job(1'b0, 9'($urandom), -1, -1, 5, 1'b0, 100, 1'b0, "abort");
    run_job(1'b0, 9'($urandom), -1, -1, $urandom_range(1, 8), 1'b0, -1, 1'b0, "m0_fresh");
    run_job(1'b1, 9'($urandom), 0, 0, $urandom_range(1, 8), 1'b1, -1, 1'b0, "m1_skip0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 Parameters SHALL be: IMG0, default 784, mode-0 feature-map bit count; IMG1, default 144, mode-1 feature-map bit count; both SHALL be nonzero multiples of 8.
REQ-002 Ports SHALL be: clk  in  1  clock; rst  in  1  reset.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be: cfg_start  in  1  job launch pulse; cfg_mode  in  1  layer mode; cfg_weight  in  9  3x3 binary kernel, bit i = tap i.
REQ-005 Ports SHALL be: s_valid  in  1  byte available; s_data  in  8  feature-map byte, LSB first; s_ready  out  1  byte accepted when s_valid&&s_ready.
REQ-006 Ports SHALL be: conv_done  in  1  completion pulse from the conv engine.
REQ-007 Ports SHALL be: start  out  1  stream active; din  out  1  feature bit; state  out  1  mode to engine; weight_en  out  1  weight bit valid; weight  out  1  weight bit.
REQ-008 Ports SHALL be: busy  out  1  job in progress; feed_done  out  1  one-cycle completion pulse; err_underrun  out  1  sticky underrun flag.

Function
REQ-009 FSM states SHALL be IDLE, LOAD_W, GAP, STREAM, WAIT_DONE, FINISH.
REQ-010 IDLE: cfg_start=1 -> latch cfg_mode and cfg_weight, clear err_underrun, go LOAD_W next cycle; cfg_start is ignored in every other state.
REQ-011 LOAD_W: 9 cycles, weight_en=1, weight=latched bit k in cycle k (k=0..8, bit 0 first) -> GAP.
REQ-012 GAP: exactly 1 cycle with weight_en=0 and start=0 -> STREAM.
REQ-013 STREAM: start=1 for exactly N cycles (N=IMG0 if mode 0, else IMG1), one din bit per cycle, no stall cycles -> WAIT_DONE.
REQ-014 state output SHALL equal the latched mode from LOAD_W through WAIT_DONE, and 0 in IDLE.
REQ-015 Byte path: one 8-bit shift register plus one prefetch register; s_ready=1 in LOAD_W, GAP and STREAM whenever prefetch is empty, else 0; s_ready=0 in IDLE, WAIT_DONE and FINISH.
REQ-016 The shift register SHALL reload from prefetch in the cycle after its 8th bit is sent; din = shift[0]; shift right by 1 per STREAM cycle.
REQ-017 Underrun: a byte needed for the next STREAM cycle but absent in prefetch -> those 8 bits driven as din=0, err_underrun=1 (sticky until next launch), cycle count unaffected.
REQ-018 The feeder SHALL accept exactly N/8 bytes per job; no handshake beyond N/8 within a job; bytes skipped by underrun are not fetched later.
REQ-019 WAIT_DONE: start=0; conv_done=1 -> FINISH; conv_done in any other state is ignored.
REQ-020 FINISH: feed_done=1 for one cycle -> IDLE.
REQ-021 busy=1 in every state except IDLE.
REQ-022 cfg_start and conv_done in the same cycle while IDLE: launch taken, conv_done ignored.
REQ-023 Outputs SHALL be registered; start, weight_en, weight and din SHALL change only on clk rising edges.

Reset
REQ-024 rst=1 -> IDLE; start, din, state, weight_en, weight, s_ready, busy, feed_done, err_underrun all 0; shift and prefetch registers empty.
REQ-025 rst mid-job SHALL abort immediately with no feed_done pulse; a bench-held s_valid SHALL NOT be accepted during or in the cycle of reset.

Verification
REQ-026 Mode 0, cfg_weight=9'h1A5, bytes 0x01.. supplied with no gaps -> weight sequence 1,0,1,0,0,1,0,1,1; 1 GAP cycle; 784 start cycles; din reproduces bytes LSB-first; 98 handshakes; err_underrun=0.
REQ-027 Mode 1, conv_done asserted 20 cycles after start falls -> state=1 throughout, 144 start cycles, 18 bytes, feed_done one cycle after conv_done, busy=0 the cycle after that.
REQ-028 Mode 1, s_valid held low for bytes 5 and 6 -> din=0 for bits 32..47, err_underrun=1 and held after feed_done, total start cycles still 144.
REQ-029 rst asserted on STREAM cycle 100 -> next cycle all outputs 0, no feed_done; fresh launch then runs a full correct job.
REQ-030 cfg_start pulsed during LOAD_W and STREAM -> ignored; spurious conv_done during STREAM -> ignored, WAIT_DONE still entered.
REQ-031 Back-to-back: cfg_start on the cycle after feed_done -> second job begins LOAD_W cleanly with err_underrun cleared.
